// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the stream-to-RAM FIFO controller.
//   - Default word and address widths, derived depth and count width.
//   - RAM port operation encoding used by the top-level arbiter.
//   - Read-issue helper: decides whether a read may be launched without
//     overflowing the 2-entry output buffer.
package fifo_ctrl_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;
    localparam int OB_DEPTH   = 2;
    localparam int CNT_W      = ADDR_W_DEF + 1;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } ram_op_e;

    // Slots that will be occupied after this cycle's pop (buffered words plus
    // the word already in flight from the RAM) must leave room for one more.
    // Written as an addition on both sides so the pop never underflows.
    function automatic logic rd_slot_free(input logic [1:0] ob_cnt,
                                          input logic       rd_pend,
                                          input logic       pop);
        logic [2:0] used;
        logic [2:0] limit;
        used  = {1'b0, ob_cnt} + {2'b00, rd_pend};
        limit = 3'd1 + {2'b00, pop};
        return (used <= limit);
    endfunction

endpackage

// File: rtl/ram_fifo_out_buf.sv
// Two-entry output buffer fed by the RAM's registered read port.
//   clk, rst    : clock, synchronous active-high reset (occupancy only)
//   push        : RAM read data in push_data is valid this cycle
//   push_data   : word returned by the RAM
//   pop         : consumer takes the head word this cycle
//   head        : oldest buffered word (entry 0)
//   ob_cnt      : number of buffered words, 0..2
// A pop shifts entry 1 into entry 0; a same-cycle push lands at the tail
// left after that pop. The caller guarantees push never overflows.
module ram_fifo_out_buf
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        ob_cnt
);

    logic [DATA_W-1:0] ob0_q, ob0_d;
    logic [DATA_W-1:0] ob1_q, ob1_d;
    logic [1:0]        ob_cnt_q, ob_cnt_d;
    logic [1:0]        tail;

    always_comb begin
        ob0_d    = ob0_q;
        ob1_d    = ob1_q;
        tail     = ob_cnt_q - {1'b0, pop};
        ob_cnt_d = ob_cnt_q - {1'b0, pop} + {1'b0, push};
        if (pop) begin
            ob0_d = ob1_q;
        end
        if (push) begin
            if (tail == 2'd0) begin
                ob0_d = push_data;
            end else begin
                ob1_d = push_data;
            end
        end
    end

    // Data entries carry no reset; only the occupancy is cleared.
    always_ff @(posedge clk) begin
        ob0_q <= ob0_d;
        ob1_q <= ob1_d;
        if (rst) begin
            ob_cnt_q <= 2'd0;
        end else begin
            ob_cnt_q <= ob_cnt_d;
        end
    end

    assign head   = ob0_q;
    assign ob_cnt = ob_cnt_q;

endmodule

// File: rtl/ram_fifo_ctrl_32x256.sv
// Stream-to-RAM FIFO controller driving the single port of a 32x256 RAM
// with 1-cycle registered read.
//   clk, rst         : clock, synchronous active-high reset
//   s_valid/s_ready  : input stream handshake, s_data input word
//   m_valid/m_ready  : output stream handshake, m_data head word
//   count            : words held (RAM + in-flight read + output buffer)
//   ram_we/ram_addr  : RAM port control, ram_din write data
//   ram_dout         : RAM read data, valid one cycle after the read address
// One RAM operation per cycle; reads win over writes so the output buffer
// stays fed and the output can sustain one word per cycle.
module ram_fifo_ctrl_32x256
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W:0]   count,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int MEM_CNT_W = ADDR_W + 1;
    localparam logic [MEM_CNT_W-1:0] MEM_FULL = MEM_CNT_W'(2 ** ADDR_W);

    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [MEM_CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic                 rd_pend_q, rd_pend_d;

    logic       pop;
    logic       rd_issue;
    logic       wr;
    logic [1:0] ob_cnt;
    ram_op_e    op;

    // Arbitration: a read is launched whenever the RAM holds data and the
    // output buffer will still have a free slot when that read returns.
    always_comb begin
        m_valid  = !rst && (ob_cnt != 2'd0);
        pop      = m_valid && m_ready;
        rd_issue = !rst && (mem_cnt_q != '0) && rd_slot_free(ob_cnt, rd_pend_q, pop);
        s_ready  = !rst && (mem_cnt_q != MEM_FULL) && !rd_issue;
        wr       = s_valid && s_ready;
        if (rd_issue) begin
            op = OP_READ;
        end else if (wr) begin
            op = OP_WRITE;
        end else begin
            op = OP_IDLE;
        end
    end

    // RAM port mux; idle cycles park the address on the read pointer.
    always_comb begin
        ram_we   = (op == OP_WRITE);
        ram_addr = (op == OP_WRITE) ? wr_ptr_q : rd_ptr_q;
        ram_din  = s_data;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_cnt_d = mem_cnt_q;
        rd_pend_d = 1'b0;
        if (op == OP_WRITE) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            mem_cnt_d = mem_cnt_q + 1'b1;
        end else if (op == OP_READ) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            mem_cnt_d = mem_cnt_q - 1'b1;
            rd_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // The word read last cycle arrives now and is pushed into the buffer.
    ram_fifo_out_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend_q),
        .push_data (ram_dout),
        .pop       (pop),
        .head      (m_data),
        .ob_cnt    (ob_cnt)
    );

    always_comb begin
        if (rst) begin
            count = '0;
        end else begin
            count = mem_cnt_q + MEM_CNT_W'(rd_pend_q) + MEM_CNT_W'(ob_cnt);
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl_32x256.sv
// Directed self-checking bench for ram_fifo_ctrl_32x256 with a behavioural
// 256x32 registered-read RAM and a queue-based scoreboard.
module tb_ram_fifo_ctrl_32x256;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [8:0]  count;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    logic [31:0] ram_mem [256];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          pop_cnt = 0;
    logic [31:0] addr_of_256 = 32'hFFFF;
    logic [31:0] last_wr_addr = 32'hFFFF;

    ram_fifo_ctrl_32x256 dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .count    (count),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: count must equal words accepted and not yet popped.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check_eq("count_track", 32'(count), 32'(exp_q.size()));
            if (ram_we) begin
                last_wr_addr = 32'(ram_addr);
                if (ram_din == 32'd256) addr_of_256 = 32'(ram_addr);
            end
            if (m_valid && m_ready) begin
                check_eq("pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_eq("data", m_data, exp_q.pop_front());
                pop_cnt++;
            end
            if (s_valid && s_ready) exp_q.push_back(s_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while (count != 0 && g < 2000) begin
            tick();
            g++;
        end
        check_eq("drain_count", 32'(count), 32'd0);
    endtask

    task automatic run_stream(input int nwords, input bit rnd, input logic [31:0] base);
        int sent;
        int cyc;
        int pops0;
        sent = 0;
        cyc = 0;
        pops0 = pop_cnt;
        s_data = base;
        s_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        m_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        while ((pop_cnt - pops0 < nwords) && cyc < 40 * nwords + 100) begin
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            tick();
            cyc++;
            s_data = base + sent;
            s_valid = (sent < nwords) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            m_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
        check_eq("stream_pops", 32'(pop_cnt - pops0), 32'(nwords));
        check_eq("stream_sent", 32'(sent), 32'(nwords));
    endtask

    initial begin
        #800000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic exp_rdy [6];
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check_eq("rst_s_ready", 32'(s_ready), 32'd0);
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_ram_we", 32'(ram_we), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_s_ready", 32'(s_ready), 32'd1);
        check_eq("post_rst_m_valid", 32'(m_valid), 32'd0);

        // Test 1: single word latency N -> N+3
        tick();
        s_valid = 1'b1;
        s_data = 32'hDEADBEEF;
        m_ready = 1'b1;
        @(negedge clk);
        check_eq("t1_accept", 32'(s_ready), 32'd1);
        check_eq("t1_addr0", 32'(ram_addr), 32'd0);
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_n1_mvalid", 32'(m_valid), 32'd0);
        tick();
        @(negedge clk);
        check_eq("t1_n2_mvalid", 32'(m_valid), 32'd0);
        tick();
        @(negedge clk);
        check_eq("t1_n3_mvalid", 32'(m_valid), 32'd1);
        check_eq("t1_n3_mdata", m_data, 32'hDEADBEEF);
        check_eq("t1_n3_count", 32'(count), 32'd1);
        tick();
        @(negedge clk);
        check_eq("t1_after_pop_count", 32'(count), 32'd0);
        check_eq("t1_after_pop_mvalid", 32'(m_valid), 32'd0);

        // Test 5: read priority pattern from empty with m_ready low
        do_reset();
        exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        s_valid = 1'b1;
        s_data = 32'h50;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq($sformatf("t5_s_ready_%0d", i), 32'(s_ready), 32'(exp_rdy[i]));
            check_eq($sformatf("t5_ram_we_%0d", i), 32'(ram_we), 32'(exp_rdy[i]));
            tick();
            if (exp_rdy[i]) s_data = s_data + 1;
        end
        drain();

        // Test 2: fill to 258 with no consumer
        do_reset();
        addr_of_256 = 32'hFFFF;
        n = 0;
        s_valid = 1'b1;
        s_data = 0;
        repeat (600) begin
            @(negedge clk);
            if (s_valid && s_ready) n++;
            tick();
            s_data = 32'(n);
            if (n == 300) s_valid = 1'b0;
        end
        s_valid = 1'b0;
        @(negedge clk);
        check_eq("t2_accepted", 32'(n), 32'd258);
        check_eq("t2_count", 32'(count), 32'd258);
        check_eq("t2_s_ready", 32'(s_ready), 32'd0);
        check_eq("t2_head", m_data, 32'd0);
        check_eq("t2_wrap_addr", addr_of_256, 32'd0);
        drain();

        // Test 3: full-rate streaming, 600 words
        run_stream(600, 1'b0, 32'h3000_0000);
        @(negedge clk);
        check_eq("t3_count_end", 32'(count), 32'd0);

        // Test 4: random valid/ready, 5000 words
        run_stream(5000, 1'b1, 32'h4000_0000);
        drain();

        // Test 6: reset mid-stream with 100 words held
        m_ready = 1'b0;
        n = 0;
        s_valid = 1'b1;
        s_data = 32'h6000_0000;
        while (n < 100) begin
            @(negedge clk);
            if (s_valid && s_ready) n++;
            tick();
            s_data = 32'h6000_0000 + n;
            if (n == 100) s_valid = 1'b0;
        end
        repeat (3) tick();
        @(negedge clk);
        check_eq("t6_count100", 32'(count), 32'd100);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_count", 32'(count), 32'd0);
        check_eq("t6_rst_s_ready", 32'(s_ready), 32'd0);
        check_eq("t6_rst_ram_we", 32'(ram_we), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_post_count", 32'(count), 32'd0);
        check_eq("t6_post_mvalid", 32'(m_valid), 32'd0);
        tick();
        s_valid = 1'b1;
        s_data = 32'hC0FFEE01;
        @(negedge clk);
        check_eq("t6_wr_we", 32'(ram_we), 32'd1);
        check_eq("t6_wr_addr", 32'(ram_addr), 32'd0);
        tick();
        s_valid = 1'b0;
        m_ready = 1'b1;
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("t6_first_mvalid", 32'(m_valid), 32'd1);
        check_eq("t6_first_data", m_data, 32'hC0FFEE01);
        drain();
        check_eq("t6_last_wr_addr", last_wr_addr, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
